gate_controller: RTL and testbench
==================================

GATE_CONTROLLER -- requirements
Module: gate_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to accept a sensor event (range 1-15).
REQ-002 Parameter ACK_WAIT, default 3: cycles to wait for is_open after issuing a request.
REQ-003 Parameter OPEN_CYCLES, default 16: maximum gate-open time in cycles (range 1-255).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 entry_sensor  input  1  raw, asynchronous car-at-entry detector.
REQ-007 exit_sensor  input  1  raw, asynchronous car-at-exit detector.
REQ-008 exit_slot_sel  input  2  slot being vacated, from the exit keypad; used only when an exit is captured.
REQ-009 pass_sensor  input  1  raw beam across the gate; high while a car is in the gate.
REQ-010 is_open  input  1  grant from the parking FSM.
REQ-011 is_full  input  1  full flag from the parking FSM.
REQ-012 entry_signal  output  1  one-cycle entry request to the parking FSM.
REQ-013 exit_signal  output  1  one-cycle exit request to the parking FSM.
REQ-014 exit_slot  output  2  slot latched at exit capture; held stable from the exit_signal cycle until return to IDLE.
REQ-015 gate_open  output  1  gate actuator drive.
REQ-016 denied  output  1  one-cycle pulse when a request is refused.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Each raw sensor SHALL pass through a 2-flop synchronizer, then a debounce counter that resets whenever the synchronized value is 0.
REQ-019 A debounced event SHALL fire once when the counter reaches DEBOUNCE_CYCLES; the sensor SHALL re-arm only after the synchronized value returns to 0.
REQ-020 States SHALL be IDLE, REQ, WAIT_ACK, OPEN, PASSING and DENY.
REQ-021 IDLE, exit event: latch exit_slot_sel into exit_slot, pulse exit_signal for one cycle, go to WAIT_ACK.
REQ-022 IDLE, entry event with is_full=0: pulse entry_signal for one cycle, go to WAIT_ACK.
REQ-023 IDLE, entry event with is_full=1: issue no request, go to DENY.
REQ-024 Entry and exit events in the same cycle: exit is served; the entry event is discarded, not queued.
REQ-025 Events arising outside IDLE SHALL be discarded.
REQ-026 WAIT_ACK: is_open=1 within ACK_WAIT cycles -> OPEN; otherwise -> DENY.
REQ-027 DENY: pulse denied for one cycle, return to IDLE.
REQ-028 OPEN: gate_open=1; debounced pass_sensor high -> PASSING.
REQ-029 PASSING: gate_open=1; synchronized pass_sensor low -> IDLE, gate_open=0.
REQ-030 An 8-bit timer SHALL count cycles spent in OPEN and PASSING combined; at OPEN_CYCLES -> IDLE with gate_open=0, regardless of pass_sensor.
REQ-031 entry_signal and exit_signal SHALL never be high together, and SHALL never be high for more than one consecutive cycle.
REQ-032 Latency: the request pulse SHALL appear DEBOUNCE_CYCLES+2 edges after the first edge that samples the raw sensor high, given IDLE and a stable sensor.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While reset is high: state=IDLE; entry_signal, exit_signal, gate_open, denied and busy = 0; exit_slot=2'b00; all counters and synchronizers cleared.
REQ-035 Reset asserted mid-operation SHALL close the gate immediately and drop any pending request; no pulse follows reset release.
REQ-036 After reset release, a sensor already high SHALL be debounced afresh before it can produce an event.

Verification
REQ-037 D=4, entry_sensor high from edge 0, is_full=0 -> entry_signal one cycle at edge 6, then is_open at edge 7 -> gate_open=1 from edge 8.
REQ-038 is_full=1, entry_sensor held high -> no entry_signal; denied one cycle; no second denied until the sensor drops and rises again.
REQ-039 exit_sensor and entry_sensor rise on the same edge, exit_slot_sel=2 -> exit_signal only, exit_slot=2; entry is ignored even while held.
REQ-040 Request issued, is_open never asserts (FSM full-state exit) -> denied 3 cycles after the request, gate_open stays 0.
REQ-041 Gate open, pass_sensor never asserts -> gate_open drops after 16 cycles; pass_sensor high for 2 cycles only -> no PASSING transition.
REQ-042 Reset pulse while in PASSING -> gate_open=0 and busy=0 asynchronously; held sensors re-debounce after release.

Source files
------------

// File: rtl/gate_controller_if.sv
// Gate controller signal bundle: raw sensors and parking-FSM handshake.
// master = controller side, slave = environment driving sensors and grants.
interface gate_controller_if;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] exit_slot_sel;
  logic       pass_sensor;
  logic       is_open;
  logic       is_full;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       gate_open;
  logic       denied;
  logic       busy;

  modport master (
    input  entry_sensor, exit_sensor, exit_slot_sel, pass_sensor, is_open, is_full,
    output entry_signal, exit_signal, exit_slot, gate_open, denied, busy
  );

  modport slave (
    output entry_sensor, exit_sensor, exit_slot_sel, pass_sensor, is_open, is_full,
    input  entry_signal, exit_signal, exit_slot, gate_open, denied, busy
  );
endinterface

// File: rtl/gate_controller.sv
// Parking gate controller: synchronize/debounce sensors, request the parking FSM, drive the gate.
// Request pulse lands DEBOUNCE_CYCLES+2 edges after the raw sensor is first sampled high; all outputs registered.
module gate_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_WAIT        = 3,
  parameter int OPEN_CYCLES     = 16
) (
  input logic               clk,
  input logic               reset,
  gate_controller_if.master gif
);
  localparam int S_ENTRY = 0;
  localparam int S_EXIT  = 1;
  localparam int S_PASS  = 2;
  localparam logic [4:0] DEB_HIT   = 5'(DEBOUNCE_CYCLES);
  localparam logic [4:0] DEB_SAT   = 5'(DEBOUNCE_CYCLES + 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_WAIT - 1);
  localparam logic [7:0] OPEN_LAST = 8'(OPEN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, OPEN, PASSING, DENY} state_t;

  logic [2:0] sensor_raw;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0] deb_cnt_q [3];
  logic [4:0] deb_cnt_d [3];
  logic       entry_evt, exit_evt, pass_deb;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] exit_slot_q, exit_slot_d;
  logic       entry_signal_q, entry_signal_d;
  logic       exit_signal_q, exit_signal_d;
  logic       gate_open_q, gate_open_d;
  logic       denied_q, denied_d;
  logic       busy_q, busy_d;

  assign sensor_raw = {gif.pass_sensor, gif.exit_sensor, gif.entry_sensor};

  // Counter saturates one past the hit value so each high run yields exactly one event.
  always_comb begin
    sync1_d = sensor_raw;
    sync2_d = sync1_q;
    for (int i = 0; i < 3; i++) begin
      if (!sync2_q[i])
        deb_cnt_d[i] = '0;
      else if (deb_cnt_q[i] == DEB_SAT)
        deb_cnt_d[i] = deb_cnt_q[i];
      else
        deb_cnt_d[i] = deb_cnt_q[i] + 5'd1;
    end
  end

  assign entry_evt = (deb_cnt_q[S_ENTRY] == DEB_HIT);
  assign exit_evt  = (deb_cnt_q[S_EXIT] == DEB_HIT);
  assign pass_deb  = (deb_cnt_q[S_PASS] >= DEB_HIT);

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timer_d        = timer_q;
    exit_slot_d    = exit_slot_q;
    entry_signal_d = 1'b0;
    exit_signal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (exit_evt) begin
          exit_slot_d   = gif.exit_slot_sel;
          exit_signal_d = 1'b1;
          state_d       = REQ;
        end else if (entry_evt) begin
          if (gif.is_full) begin
            state_d = DENY;
          end else begin
            entry_signal_d = 1'b1;
            state_d        = REQ;
          end
        end
      end
      // REQ is the pulse cycle and already counts as the first acknowledge window cycle.
      REQ, WAIT_ACK: begin
        if (gif.is_open) begin
          timer_d = '0;
          state_d = OPEN;
        end else if (wait_cnt_q == ACK_LAST) begin
          state_d = DENY;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          state_d    = WAIT_ACK;
        end
      end
      OPEN: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == OPEN_LAST)
          state_d = IDLE;
        else if (pass_deb)
          state_d = PASSING;
      end
      PASSING: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == OPEN_LAST || !sync2_q[S_PASS])
          state_d = IDLE;
      end
      DENY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gate_open_d = (state_d == OPEN) || (state_d == PASSING);
    denied_d    = (state_d == DENY);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      timer_q        <= '0;
      exit_slot_q    <= '0;
      entry_signal_q <= 1'b0;
      exit_signal_q  <= 1'b0;
      gate_open_q    <= 1'b0;
      denied_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      timer_q        <= timer_d;
      exit_slot_q    <= exit_slot_d;
      entry_signal_q <= entry_signal_d;
      exit_signal_q  <= exit_signal_d;
      gate_open_q    <= gate_open_d;
      denied_q       <= denied_d;
      busy_q         <= busy_d;
    end
  end

  assign gif.entry_signal = entry_signal_q;
  assign gif.exit_signal  = exit_signal_q;
  assign gif.exit_slot    = exit_slot_q;
  assign gif.gate_open    = gate_open_q;
  assign gif.denied       = denied_q;
  assign gif.busy         = busy_q;
endmodule

// File: tb/tb_gate_controller.sv
// Bench for gate_controller: history-based reference model compared every cycle plus directed literal checks.
module tb_gate_controller;
  localparam int D        = 4;
  localparam int ACK_WAIT = 3;
  localparam int OPEN_CYC = 16;

  logic clk;
  logic reset;
  gate_controller_if gif();

  gate_controller dut (.clk(clk), .reset(reset), .gif(gif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: sensor history since reset; edge n sees raw(n-2) synchronized, debounce run ending at n-3.
  typedef enum {M_IDLE, M_ACK, M_GATE, M_DENY} mmode_t;
  mmode_t     m_mode;
  int         m_edge, m_req_edge, m_open_edge;
  bit         m_passing;
  logic [2:0] raw_hist[$];
  logic       e_entry, e_exit, e_gate, e_denied, e_busy;
  logic [1:0] e_slot;
  bit         ev_entry, ev_exit, pass_deb, pass_sync;

  function automatic int run_at(input int back, input int s);
    int idx = raw_hist.size() - 1 - back;
    int r = 0;
    while (idx >= 0 && raw_hist[idx][s]) begin
      r++;
      idx--;
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_hist.delete();
      m_mode = M_IDLE; m_edge = 0; m_passing = 0;
      e_entry = 0; e_exit = 0; e_gate = 0; e_denied = 0; e_busy = 0; e_slot = 2'd0;
    end else begin
      raw_hist.push_back({gif.pass_sensor, gif.exit_sensor, gif.entry_sensor});
      if (raw_hist.size() > 24) void'(raw_hist.pop_front());
      ev_entry  = (run_at(3, 0) == D);
      ev_exit   = (run_at(3, 1) == D);
      pass_deb  = (run_at(3, 2) >= D);
      pass_sync = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3][2] : 1'b0;
      e_entry = 0; e_exit = 0;
      case (m_mode)
        M_IDLE: begin
          if (ev_exit) begin
            e_slot = gif.exit_slot_sel; e_exit = 1; m_mode = M_ACK; m_req_edge = m_edge;
          end else if (ev_entry) begin
            if (gif.is_full) m_mode = M_DENY;
            else begin e_entry = 1; m_mode = M_ACK; m_req_edge = m_edge; end
          end
        end
        M_ACK: begin
          if (gif.is_open) begin m_mode = M_GATE; m_open_edge = m_edge; m_passing = 0; end
          else if (m_edge - m_req_edge >= ACK_WAIT) m_mode = M_DENY;
        end
        M_GATE: begin
          if (m_edge - m_open_edge >= OPEN_CYC) m_mode = M_IDLE;
          else if (!m_passing) m_passing = pass_deb;
          else if (!pass_sync) m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
      e_gate   = (m_mode == M_GATE);
      e_denied = (m_mode == M_DENY);
      e_busy   = (m_mode != M_IDLE);
      m_edge++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_entry_signal", gif.entry_signal, e_entry);
      check("cmp_exit_signal", gif.exit_signal, e_exit);
      check("cmp_exit_slot", gif.exit_slot, e_slot);
      check("cmp_gate_open", gif.gate_open, e_gate);
      check("cmp_denied", gif.denied, e_denied);
      check("cmp_busy", gif.busy, e_busy);
    end
  end

  task automatic wait_idle(input string name, input int lim);
    int k = 0;
    while (gif.busy && k < lim) begin
      step(1);
      k++;
    end
    check(name, gif.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ng;
    int nd;
    reset = 1'b1;
    gif.entry_sensor = 0; gif.exit_sensor = 0; gif.exit_slot_sel = 2'd0;
    gif.pass_sensor = 0; gif.is_open = 0; gif.is_full = 0;
    step(2);
    check("rst_gate_open", gif.gate_open, 0);
    check("rst_busy", gif.busy, 0);
    check("rst_exit_slot", gif.exit_slot, 0);
    step(1);
    reset = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Entry, grant, car passes through.
    gif.entry_sensor = 1;
    step(6); check("t1_no_early_req", gif.entry_signal, 0);
    step(1); check("t1_entry_req_edge6", gif.entry_signal, 1);
    check("t1_busy", gif.busy, 1);
    gif.entry_sensor = 0;
    step(1); check("t1_pulse_one_cycle", gif.entry_signal, 0);
    check("t1_gate_still_closed", gif.gate_open, 0);
    gif.is_open = 1;
    step(1); check("t1_gate_open_edge8", gif.gate_open, 1);
    gif.is_open = 0;
    gif.pass_sensor = 1;
    step(8);
    gif.pass_sensor = 0;
    wait_idle("t1_return_idle", 40);
    check("t1_gate_closed", gif.gate_open, 0);
    step(3);

    // Lot full: one denial per sensor assertion.
    gif.is_full = 1;
    gif.entry_sensor = 1;
    step(7); check("t2_denied", gif.denied, 1);
    check("t2_no_entry_req", gif.entry_signal, 0);
    step(1); check("t2_denied_one_cycle", gif.denied, 0);
    nd = 0;
    repeat (20) begin step(1); nd += int'(gif.denied); end
    check("t2_no_repeat_deny", 8'(nd), 0);
    gif.entry_sensor = 0;
    step(3);
    gif.entry_sensor = 1;
    step(7); check("t2_deny_after_rearm", gif.denied, 1);
    gif.entry_sensor = 0;
    gif.is_full = 0;
    step(4);

    // Simultaneous exit and entry; gate times out with short pass blip.
    gif.exit_slot_sel = 2'd2;
    gif.exit_sensor = 1;
    gif.entry_sensor = 1;
    step(7); check("t3_exit_req", gif.exit_signal, 1);
    check("t3_no_entry_req", gif.entry_signal, 0);
    check("t3_exit_slot", gif.exit_slot, 2);
    gif.exit_slot_sel = 2'd1;
    step(1); check("t3_exit_one_cycle", gif.exit_signal, 0);
    gif.is_open = 1;
    step(1); check("t3_gate_open", gif.gate_open, 1);
    check("t3_slot_held", gif.exit_slot, 2);
    gif.is_open = 0;
    ng = 1;
    gif.pass_sensor = 1;
    step(1); ng += int'(gif.gate_open);
    step(1); ng += int'(gif.gate_open);
    gif.pass_sensor = 0;
    repeat (28) begin step(1); ng += int'(gif.gate_open); end
    check("t3_open_cycles", 8'(ng), 8'(OPEN_CYC));
    gif.exit_sensor = 0;
    gif.entry_sensor = 0;
    step(4);

    // Grant never arrives.
    gif.entry_sensor = 1;
    step(7); check("t4_entry_req", gif.entry_signal, 1);
    gif.entry_sensor = 0;
    step(2); check("t4_not_yet_denied", gif.denied, 0);
    step(1); check("t4_denied_after_3", gif.denied, 1);
    check("t4_gate_closed", gif.gate_open, 0);
    step(1); check("t4_idle", gif.busy, 0);
    step(3);

    // Reset while passing; held entry sensor re-debounces.
    gif.entry_sensor = 1;
    step(7); check("t5_entry_req", gif.entry_signal, 1);
    step(1);
    gif.is_open = 1;
    step(1);
    gif.is_open = 0;
    gif.pass_sensor = 1;
    step(10);
    check("t5_passing_gate", gif.gate_open, 1);
    check("t5_passing_busy", gif.busy, 1);
    #2 reset = 1'b1;
    #1 check("t5_async_gate", gif.gate_open, 0);
    check("t5_async_busy", gif.busy, 0);
    step(2);
    reset = 1'b0;
    gif.pass_sensor = 0;
    step(6); check("t5_no_early_req", gif.entry_signal, 0);
    step(1); check("t5_redebounced_req", gif.entry_signal, 1);
    gif.entry_sensor = 0;
    step(3); check("t5_timeout_deny", gif.denied, 1);
    wait_idle("t5_return_idle", 10);
    step(3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
